// File: rtl/aes_dec_block_loader.sv
// Byte-serial loader for the AES decryption core: assembles key and
// ciphertext frames from an 8-bit valid/ready stream into held registers.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   s_byte/s_valid/s_ready      input byte stream handshake
//   s_key                       frame type on first byte (1 = key frame)
//   s_last                      final byte marker (early = discard)
//   blk_data/blk_valid/blk_ready  held 128-bit ciphertext block
//   key_data/key_valid          held KW-bit key, valid is sticky
//   err                         one-cycle pulse when a frame is discarded
//
// Bit 0 of blk_data/key_data is the MSB of the first byte, so both
// vectors use ascending ranges; byte n sits in [8n : 8n+7].
module aes_dec_block_loader #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       s_byte,
   input  logic             s_valid,
   input  logic             s_key,
   input  logic             s_last,
   output logic             s_ready,
   output logic [0:127]     blk_data,
   output logic             blk_valid,
   input  logic             blk_ready,
   output logic [0:32*Nk-1] key_data,
   output logic             key_valid,
   output logic             err
);

   localparam int KW = 32 * Nk;
   localparam int KB = 4 * Nk;
   localparam int CW = $clog2(KB + 1);

   // Nr only has to agree with Nk for the downstream core.
   if (!((Nk == 4 && Nr == 10) ||
         (Nk == 6 && Nr == 12) ||
         (Nk == 8 && Nr == 14))) begin : g_bad_cfg
      $error("aes_dec_block_loader: unsupported Nk/Nr pair");
   end

   typedef enum logic [1:0] {
      IDLE,
      FILL_DATA,
      FILL_KEY,
      FULL
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic [CW+2:0]   pos;
   logic [0:127]    dsh;
   logic [0:127]    dsh_nxt;
   logic [0:KW-1]   ksh;
   logic [0:KW-1]   ksh_nxt;
   logic            xfer;
   logic            to_key;
   logic            final_b;
   logic            ld_blk;
   logic            ld_key;
   logic            discard;

   // Registered-state decode only: no path from blk_ready.
   assign s_ready = (state != FULL);
   assign xfer    = s_valid & s_ready;
   assign pos     = {cnt, 3'b000};

   // Frame type is latched by the state after byte 0.
   assign to_key  = (state == IDLE) ? s_key : (state == FILL_KEY);
   assign final_b = to_key ? (cnt == CW'(KB - 1)) : (cnt == CW'(15));

   // Shadow with the current byte merged in; lets the final byte land
   // in the output register in the same edge it arrives.
   always_comb begin
      dsh_nxt = dsh;
      ksh_nxt = ksh;
      if (to_key) ksh_nxt[pos +: 8] = s_byte;
      else        dsh_nxt[pos +: 8] = s_byte;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ld_blk    = 1'b0;
      ld_key    = 1'b0;
      discard   = 1'b0;
      case (state)
         IDLE, FILL_DATA, FILL_KEY: begin
            if (xfer) begin
               if (final_b) begin
                  cnt_nxt = '0;
                  if (to_key) begin
                     ld_key    = 1'b1;
                     state_nxt = IDLE;
                  end else if (key_valid) begin
                     ld_blk    = 1'b1;
                     state_nxt = FULL;
                  end else begin
                     discard   = 1'b1;
                     state_nxt = IDLE;
                  end
               end else if (s_last) begin
                  discard   = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt   = cnt + 1'b1;
                  state_nxt = to_key ? FILL_KEY : FILL_DATA;
               end
            end
         end
         FULL: begin
            if (blk_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dsh       <= '0;
         ksh       <= '0;
         blk_data  <= '0;
         blk_valid <= 1'b0;
         key_data  <= '0;
         key_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= discard;
         if (xfer) begin
            if (to_key) ksh <= ksh_nxt;
            else        dsh <= dsh_nxt;
         end
         if (ld_key) begin
            key_data  <= ksh_nxt;
            key_valid <= 1'b1;
         end
         if (ld_blk) begin
            blk_data  <= dsh_nxt;
            blk_valid <= 1'b1;
         end else if (state == FULL && blk_ready) begin
            blk_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_aes_dec_block_loader.sv
// Randomized bench for aes_dec_block_loader (Nk=4 and Nk=8 instances)
// against a frame-level model of key/block loading.
module tb_aes_dec_block_loader;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   s_byte = '0;
   logic         s_valid = 1'b0;
   logic         s_key = 1'b0;
   logic         s_last = 1'b0;
   logic         s_ready;
   logic [0:127] blk_data;
   logic         blk_valid;
   logic         blk_ready = 1'b0;
   logic [0:127] key_data;
   logic         key_valid;
   logic         err;

   logic [7:0]   e_byte = '0;
   logic         e_valid = 1'b0;
   logic         e_key = 1'b0;
   logic         e_last = 1'b0;
   logic         e_ready;
   logic [0:127] e_blk_data;
   logic         e_blk_valid;
   logic         e_blk_ready = 1'b0;
   logic [0:255] e_key_data;
   logic         e_key_valid;
   logic         e_err;

   int n_chk = 0;
   int n_pass = 0;
   int err_cnt = 0;
   int e_err_cnt = 0;

   logic [127:0] m_key = '0;
   logic         m_kv = 1'b0;
   logic [127:0] m_blk = '0;
   logic         m_bv = 1'b0;
   bit   [7:0]   fb [32];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (err) err_cnt++;
      if (e_err) e_err_cnt++;
   end

   aes_dec_block_loader #(.Nk(4), .Nr(10)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .s_byte(s_byte), .s_valid(s_valid), .s_key(s_key),
      .s_last(s_last), .s_ready(s_ready),
      .blk_data(blk_data), .blk_valid(blk_valid),
      .blk_ready(blk_ready),
      .key_data(key_data), .key_valid(key_valid), .err(err)
   );

   aes_dec_block_loader #(.Nk(8), .Nr(14)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .s_byte(e_byte), .s_valid(e_valid), .s_key(e_key),
      .s_last(e_last), .s_ready(e_ready),
      .blk_data(e_blk_data), .blk_valid(e_blk_valid),
      .blk_ready(e_blk_ready),
      .key_data(e_key_data), .key_valid(e_key_valid), .err(e_err)
   );

   task automatic send(input logic [7:0] b, input logic k,
                       input logic l);
      int n = 0;
      @(negedge clk);
      s_byte = b; s_key = k; s_last = l; s_valid = 1'b1;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_chk++;
         $display("FAIL send_timeout: s_ready=%b required 1", s_ready);
      end
      @(posedge clk);
      #1 s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic send8(input logic [7:0] b, input logic k);
      int n = 0;
      @(negedge clk);
      e_byte = b; e_key = k; e_last = 1'b0; e_valid = 1'b1;
      while (!e_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_chk++;
         $display("FAIL send8_timeout: e_ready=%b required 1", e_ready);
      end
      @(posedge clk);
      #1 e_valid = 1'b0;
   endtask

   // Sends fb[0..n-1] as one frame, then checks against the model.
   task automatic do_frame(input bit is_key, input int n,
                           input bit with_last, input string tag);
      int e0 = err_cnt;
      int x_err = 0;
      logic [127:0] v = '0;
      for (int i = 0; i < n; i++)
         send(fb[i], is_key, with_last && (i == n - 1));
      repeat (2) @(negedge clk);
      for (int i = 0; i < n; i++) v = {v[119:0], fb[i]};
      if (n < 16) x_err = 1;
      else if (is_key) begin m_key = v; m_kv = 1'b1; end
      else if (m_kv) begin m_blk = v; m_bv = 1'b1; end
      else x_err = 1;
      n_chk++;
      if ((err_cnt - e0) !== x_err)
         $display("FAIL %s err_pulses: got %0d want %0d", tag, err_cnt - e0, x_err);
      else n_pass++;
      n_chk++;
      if (key_valid !== m_kv)
         $display("FAIL %s key_valid: got %b want %b", tag, key_valid, m_kv);
      else n_pass++;
      n_chk++;
      if (key_data !== m_key)
         $display("FAIL %s key_data: got %h want %h", tag, key_data, m_key);
      else n_pass++;
      n_chk++;
      if (blk_valid !== m_bv)
         $display("FAIL %s blk_valid: got %b want %b", tag, blk_valid, m_bv);
      else n_pass++;
      n_chk++;
      if (blk_data !== m_blk)
         $display("FAIL %s blk_data: got %h want %h", tag, blk_data, m_blk);
      else n_pass++;
   endtask

   task automatic consume(input int dly);
      repeat (dly) @(negedge clk);
      @(negedge clk);
      blk_ready = 1'b1;
      @(posedge clk);
      #1 blk_ready = 1'b0;
      m_bv = 1'b0;
      n_chk++;
      if (blk_valid !== 1'b0 || s_ready !== 1'b1)
         $display("FAIL consume: blk_valid=%b s_ready=%b want 0/1", blk_valid, s_ready);
      else n_pass++;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_chk++;
      if ({blk_valid, key_valid, err} !== 3'b000 || blk_data !== '0 || key_data !== '0)
         $display("FAIL reset_outputs: bv=%b kv=%b err=%b blk=%h key=%h want all 0",
                  blk_valid, key_valid, err, blk_data, key_data);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (s_ready !== 1'b1 || e_ready !== 1'b1)
         $display("FAIL reset_ready: s_ready=%b e_ready=%b want 1", s_ready, e_ready);
      else n_pass++;
   endtask

   task automatic test_no_key();
      for (int i = 0; i < 16; i++) send(8'($urandom), 1'b0, 1'b0);
      n_chk++;
      if (err !== 1'b1) $display("FAIL nokey_err_pulse: got %b want 1", err);
      else n_pass++;
      @(posedge clk);
      #1;
      n_chk++;
      if (err !== 1'b0) $display("FAIL nokey_err_single: got %b want 0", err);
      else n_pass++;
      n_chk++;
      if (blk_valid !== 1'b0 || key_valid !== 1'b0)
         $display("FAIL nokey_valids: bv=%b kv=%b want 0/0", blk_valid, key_valid);
      else n_pass++;
   endtask

   task automatic test_key_load();
      for (int i = 0; i < 16; i++) fb[i] = 8'(i);
      do_frame(1'b1, 16, 1'b0, "key_load");
      n_chk++;
      if (key_data !== 128'h000102030405060708090a0b0c0d0e0f)
         $display("FAIL key_load_const: got %h want 000102030405060708090a0b0c0d0e0f",
                  key_data);
      else n_pass++;
   endtask

   task automatic test_block_load();
      logic [127:0] ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      for (int i = 0; i < 15; i++) send(ct[127-8*i -: 8], 1'b0, 1'b0);
      n_chk++;
      if (blk_valid !== 1'b0) $display("FAIL blk_early: blk_valid=%b want 0", blk_valid);
      else n_pass++;
      send(ct[7:0], 1'b0, 1'b0);
      n_chk++;
      if (blk_valid !== 1'b1) $display("FAIL blk_latency: blk_valid=%b want 1", blk_valid);
      else n_pass++;
      n_chk++;
      if (blk_data !== ct) $display("FAIL blk_data: got %h want %h", blk_data, ct);
      else n_pass++;
      m_blk = ct;
      m_bv = 1'b1;
   endtask

   task automatic test_backpressure();
      bit bad = 1'b0;
      @(negedge clk);
      s_byte = 8'haa; s_key = 1'b0; s_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (s_ready !== 1'b0 || blk_valid !== 1'b1 || blk_data !== m_blk) bad = 1'b1;
      end
      n_chk++;
      if (bad) $display("FAIL backpressure_hold: s_ready=%b bv=%b blk=%h want 0/1/%h",
                        s_ready, blk_valid, blk_data, m_blk);
      else n_pass++;
      s_valid = 1'b0;
      consume(0);
      for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
      do_frame(1'b0, 16, 1'b0, "after_bp");
      consume(1);
   endtask

   task automatic test_short_frame();
      for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
      do_frame(1'b0, 10, 1'b1, "short_frame");
      for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
      do_frame(1'b0, 16, 1'b1, "full_with_last");
      consume(2);
   endtask

   task automatic test_random();
      for (int it = 0; it < 30; it++) begin
         int r = $urandom_range(0, 9);
         for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
         if (r < 2) do_frame(1'b1, 16, 1'($urandom), "rnd_key");
         else if (r < 4) do_frame(1'($urandom), $urandom_range(1, 15), 1'b1, "rnd_short");
         else begin
            do_frame(1'b0, 16, 1'($urandom), "rnd_data");
            if (m_bv) consume($urandom_range(0, 3));
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 7; i++) send(8'($urandom), 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      m_kv = 1'b0; m_key = '0; m_blk = '0; m_bv = 1'b0;
      n_chk++;
      if ({blk_valid, key_valid, err} !== 3'b000 || blk_data !== '0 || key_data !== '0)
         $display("FAIL midreset_outputs: bv=%b kv=%b err=%b blk=%h key=%h want all 0",
                  blk_valid, key_valid, err, blk_data, key_data);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (s_ready !== 1'b1) $display("FAIL midreset_ready: got %b want 1", s_ready);
      else n_pass++;
      for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
      do_frame(1'b0, 16, 1'b0, "after_reset_nokey");
   endtask

   task automatic test_key_reload8();
      logic [255:0] ka;
      logic [255:0] kb;
      int e0 = e_err_cnt;
      ka = {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
      kb = {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 32; i++) send8(ka[255-8*i -: 8], 1'b1);
      n_chk++;
      if (e_key_valid !== 1'b1 || e_key_data !== ka)
         $display("FAIL key8_first: kv=%b key=%h want 1/%h", e_key_valid, e_key_data, ka);
      else n_pass++;
      for (int i = 0; i < 10; i++) send8(kb[255-8*i -: 8], 1'b1);
      n_chk++;
      if (e_key_valid !== 1'b1 || e_key_data !== ka)
         $display("FAIL key8_partial: kv=%b key=%h want 1/%h", e_key_valid, e_key_data, ka);
      else n_pass++;
      for (int i = 10; i < 32; i++) send8(kb[255-8*i -: 8], 1'b0);
      repeat (2) @(negedge clk);
      n_chk++;
      if (e_key_data !== kb)
         $display("FAIL key8_reload: key=%h want %h", e_key_data, kb);
      else n_pass++;
      n_chk++;
      if (e_err_cnt - e0 !== 0)
         $display("FAIL key8_err: got %0d pulses want 0", e_err_cnt - e0);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_no_key();
      test_key_load();
      test_block_load();
      test_backpressure();
      test_short_frame();
      test_random();
      test_key_reload8();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
